idct_tpose_ctrl: RTL

Ping-pong sequencer for the IDCT transpose buffer (the dual-bank 16-bit `RAM` between the row and column 1-D IDCT stages). Accepts row-stage coefficients on a valid/ready stream and writes them row-major into the current write bank. Reads the other bank column-major to feed the column stage. Swaps banks only when both the write and read block are complete, and drives `mode`, `wr_rd`, the addresses and the write data for 8x8 or 4x4 transforms.

---
 rtl/idct_tpose_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/idct_tpose_ctrl.sv
// ---------------------------------------------------------------------------
// idct_tpose_ctrl
//
// Ping-pong sequencer for the IDCT transpose buffer. This block sits between
// the row and column 1-D IDCT stages and controls an external dual-bank
// 16-bit RAM.
//
// Data flow:
//   - Row-stage coefficients arrive on a valid/ready stream. They are written
//     row-major into the current write bank.
//   - The other bank is read column-major to feed the column stage.
//   - The banks swap only when the write bank holds a complete block and the
//     read bank has been fully issued, with no read still in the pipeline.
//
// Ports:
//   clk, rst_n      rising-edge clock; asynchronous active-low reset
//   cfg_mode[1:0]   requested block size: 01 = 8x8, 00 = 4x4, 1x = 8x8
//   in_valid        row-stage beat valid
//   in_ready        controller can accept a beat
//   in_data[15:0]   row-stage coefficient
//   out_en          column stage takes a beat issued this cycle
//   out_valid       out_data valid
//   out_last        final beat of a block
//   out_data[15:0]  pass-through of ram_data_out
//   ram_wr_rd       RAM bank select: 0 = write ram1 / read ram2
//   ram_mode[1:0]   RAM block-size mode (the active mode)
//   ram_wr_addr, ram_rd_addr [5:0], ram_data_in[15:0]  RAM write/read port
//   ram_data_out[15:0]  RAM registered read data
//   blk_done        one-cycle pulse on every bank swap
//
// Build option:
//   IDCT_TPOSE_4X4_EN
//     Defined:   4x4 blocks can be selected through cfg_mode.
//     Undefined: the active mode is fixed at 8x8, and cfg_mode is ignored.
// ---------------------------------------------------------------------------
module idct_tpose_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  cfg_mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        out_en,
    output logic        out_valid,
    output logic        out_last,
    output logic [15:0] out_data,
    output logic        ram_wr_rd,
    output logic [1:0]  ram_mode,
    output logic [5:0]  ram_wr_addr,
    output logic [5:0]  ram_rd_addr,
    output logic [15:0] ram_data_in,
    input  logic [15:0] ram_data_out,
    output logic        blk_done
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  mode_reg;        // active block-size mode
    logic [5:0]  wcnt_reg;        // next write index (row-major)
    logic        wfull_reg;       // write bank holds a complete block
    logic [5:0]  rcnt_reg;        // next read index (column-major order)
    logic        rfull_reg;       // read bank holds unissued beats
    logic        iss_v_reg;       // pipeline stage 1: a read was issued
    logic        iss_last_reg;    // stage 1: that issue was the block's last
    logic        out_valid_reg;   // pipeline stage 2: aligned with RAM data
    logic        out_last_reg;
    logic        wr_rd_reg;
    logic        blk_done_reg;
    logic [5:0]  wr_addr_reg;
    logic [15:0] data_in_reg;
    logic [5:0]  rd_addr_reg;

    // -----------------------------------------------------------------------
    // Mode decode
    // -----------------------------------------------------------------------
    logic       is_4x4;
    logic [5:0] last_idx;         // BLK-1 for the active mode

`ifdef IDCT_TPOSE_4X4_EN
    assign is_4x4 = (mode_reg == 2'b00);
`else
    assign is_4x4 = 1'b0;
    // cfg_mode has no function in an 8x8-only build.
    logic unused_cfg_mode;
    assign unused_cfg_mode = ^cfg_mode;
`endif

    assign last_idx = is_4x4 ? 6'd15 : 6'd63;

    // -----------------------------------------------------------------------
    // Transpose address generation
    //
    // rcnt counts through the block in column-major order. Swapping its row
    // and column fields gives the row-major address where that beat was
    // written.
    // -----------------------------------------------------------------------
    logic [5:0] tp8_addr;
    logic [5:0] rd_addr_next;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tp8
            assign tp8_addr[gi + 3] = rcnt_reg[gi];
            assign tp8_addr[gi]     = rcnt_reg[gi + 3];
        end
    endgenerate

`ifdef IDCT_TPOSE_4X4_EN
    logic [5:0] tp4_addr;

    assign tp4_addr[5:4] = 2'b00;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tp4
            assign tp4_addr[gi + 2] = rcnt_reg[gi];
            assign tp4_addr[gi]     = rcnt_reg[gi + 2];
        end
    endgenerate

    assign rd_addr_next = is_4x4 ? tp4_addr : tp8_addr;
`else
    assign rd_addr_next = tp8_addr;
`endif

    // -----------------------------------------------------------------------
    // Handshakes and control conditions
    // -----------------------------------------------------------------------
    logic accept;
    logic issue;
    logic w_last;
    logic r_last;
    logic swap;
    logic idle;

    assign accept = in_valid && !wfull_reg;
    assign issue  = rfull_reg && out_en;
    assign w_last = (wcnt_reg == last_idx);
    assign r_last = (rcnt_reg == last_idx);

    // Swap conditions:
    //   - A beat issued on the previous edge still has iss_v_reg set, so
    //     the swap waits at least one cycle after the final issue. The RAM
    //     read for that beat therefore completes on the old bank.
    //   - wfull_reg blocks further accepts. The final write therefore lands
    //     on the same edge as the swap, while the RAM still sees the old
    //     ram_wr_rd.
    assign swap = wfull_reg && !rfull_reg && !iss_v_reg;

    // Both banks are empty and nothing is in flight. This is the only time
    // the block size may change.
    assign idle = !wfull_reg && (wcnt_reg == 6'd0) && !rfull_reg
                  && !iss_v_reg && !out_valid_reg;

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg      <= 2'b01;
            wcnt_reg      <= 6'd0;
            wfull_reg     <= 1'b0;
            rcnt_reg      <= 6'd0;
            rfull_reg     <= 1'b0;
            iss_v_reg     <= 1'b0;
            iss_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            wr_rd_reg     <= 1'b0;
            blk_done_reg  <= 1'b0;
        end else begin
            blk_done_reg <= 1'b0;

            // Write side: count beats of the current block.
            if (accept) begin
                if (w_last) begin
                    wcnt_reg  <= 6'd0;
                    wfull_reg <= 1'b1;
                end else begin
                    wcnt_reg <= wcnt_reg + 6'd1;
                end
            end

            // Read side: issue column-major reads while the bank has data.
            if (issue) begin
                if (r_last) begin
                    rcnt_reg  <= 6'd0;
                    rfull_reg <= 1'b0;
                end else begin
                    rcnt_reg <= rcnt_reg + 6'd1;
                end
            end

            // Two-stage issue-to-data pipeline. Stage 2 lines up with the
            // RAM's registered read data.
            iss_v_reg     <= issue;
            iss_last_reg  <= issue && r_last;
            out_valid_reg <= iss_v_reg;
            out_last_reg  <= iss_last_reg;

            // Swap is exclusive with accept (it needs wfull) and with
            // issue (it needs !rfull), so these updates cannot collide.
            if (swap) begin
                wr_rd_reg    <= ~wr_rd_reg;
                rfull_reg    <= 1'b1;
                wfull_reg    <= 1'b0;
                blk_done_reg <= 1'b1;
            end

`ifdef IDCT_TPOSE_4X4_EN
            if (idle) begin
                mode_reg <= cfg_mode[1] ? 2'b01 : cfg_mode;
            end
`endif
        end
    end

`ifndef IDCT_TPOSE_4X4_EN
    // The mode never changes in an 8x8-only build.
    logic unused_idle;
    assign unused_idle = idle;
`endif

    // -----------------------------------------------------------------------
    // RAM address/data registers
    //
    // The RAM writes on every cycle. The write address and data are held
    // between accepts, so any repeated write stores the same value again.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= 6'd0;
            data_in_reg <= 16'd0;
            rd_addr_reg <= 6'd0;
        end else begin
            if (accept) begin
                wr_addr_reg <= wcnt_reg;
                data_in_reg <= in_data;
            end
            if (issue) begin
                rd_addr_reg <= rd_addr_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready    = !wfull_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign out_data    = ram_data_out;
    assign ram_wr_rd   = wr_rd_reg;
    assign ram_mode    = mode_reg;
    assign ram_wr_addr = wr_addr_reg;
    assign ram_rd_addr = rd_addr_reg;
    assign ram_data_in = data_in_reg;
    assign blk_done    = blk_done_reg;

endmodule
